// File: rtl/camera_pkg.sv
// Shared encodings for the MT9V034 transmit-side emulator: FSM states, pattern codes,
// and the noise LFSR constants used when CAMERA_EMULATOR_NOISE_EN is defined.
package camera_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEAD   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HBLK   = 3'd3,
        ST_VBLK   = 3'd4
    } cam_state_t;

    localparam logic [1:0]  PATTERN_RAMP    = 2'd0;
    localparam logic [1:0]  PATTERN_TAG     = 2'd1;
    localparam logic [1:0]  PATTERN_CHECKER = 2'd2;
    localparam logic [1:0]  PATTERN_FLAT    = 2'd3;
    localparam logic [9:0]  FLAT_GREY       = 10'h200;

    // Taps at bits 15,13,12,10 realise x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/camera_pattern_gen.sv
// Synthetic pixel source: maps (line, column, latched pattern select) to a 10-bit pixel.
module camera_pattern_gen
    import camera_pkg::*;
#(
    parameter int COLUMNS = 752,
    parameter int COL_W   = 10,
    parameter int LINE_W  = 9
) (
    input  logic [LINE_W-1:0] line,
    input  logic [COL_W-1:0]  col,
    input  logic [1:0]        sel,
    output logic [9:0]        pixel
);

    logic [9:0] ramp_s;
    logic [7:0] tag_s;

    // Arithmetic is carried out at the truncated widths, which is exact modulo 1024 / 256
    always_comb begin
        ramp_s = 10'(line) * 10'(COLUMNS) + 10'(col);
        tag_s  = (8'(line) + 8'd1) * 8'd10 + 8'(col) + 8'd1;
        case (sel)
            PATTERN_RAMP:    pixel = ramp_s;
            PATTERN_TAG:     pixel = {tag_s, 2'b00};
            PATTERN_CHECKER: pixel = (line[0] ^ col[0]) ? 10'h3FF : 10'h000;
            PATTERN_FLAT:    pixel = FLAT_GREY;
            default:         pixel = 10'h000;
        endcase
    end

endmodule

// File: rtl/camera_emulator.sv
// MT9V034 parallel-bus transmitter: FRAME_VALID/LINE_VALID/DATA_OUT timing plus frame counter.
// Optional `CAMERA_EMULATOR_NOISE_EN adds LFSR dither on DATA_OUT[1:0].
module camera_emulator
    import camera_pkg::*;
#(
    parameter int COLUMNS = 752,
    parameter int LINES   = 480,
    parameter int H_BLANK = 94,
    parameter int V_BLANK = 45,
    parameter int FV_LEAD = 1
) (
    input  logic       PIXCLK,
    input  logic       RESET_N,
    input  logic       ENABLE,
    input  logic [1:0] PATTERN_SEL,
    output logic       FRAME_VALID,
    output logic       LINE_VALID,
    output logic [9:0] DATA_OUT,
    output logic [7:0] FRAME_COUNT
);

    localparam int COL_W   = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int LINE_W  = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int BLK_MAX = (H_BLANK > V_BLANK) ?
                             ((H_BLANK > FV_LEAD) ? H_BLANK : FV_LEAD) :
                             ((V_BLANK > FV_LEAD) ? V_BLANK : FV_LEAD);
    localparam int CNT_W   = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLUMNS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
    localparam logic [CNT_W-1:0]  LEAD_LAST = CNT_W'(FV_LEAD - 1);
    localparam logic [CNT_W-1:0]  HB_LAST   = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0]  VB_LAST   = CNT_W'(V_BLANK - 1);

    cam_state_t        state_r, state_s;
    logic [COL_W-1:0]  col_r, col_s;
    logic [LINE_W-1:0] line_r, line_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [1:0]        sel_r, sel_s;
    logic              fv_s, lv_s;
    logic [9:0]        pixel_s, data_s;

    camera_pattern_gen #(
        .COLUMNS (COLUMNS),
        .COL_W   (COL_W),
        .LINE_W  (LINE_W)
    ) u_pattern (
        .line  (line_r),
        .col   (col_r),
        .sel   (sel_r),
        .pixel (pixel_s)
    );

    // Next-state and counter decisions; ENABLE only matters in IDLE and at the end of VBLK
    always_comb begin
        state_s = state_r;
        col_s   = col_r;
        line_s  = line_r;
        cnt_s   = cnt_r;
        sel_s   = sel_r;
        case (state_r)
            ST_IDLE: begin
                if (ENABLE) begin
                    state_s = ST_LEAD;
                    cnt_s   = '0;
                    sel_s   = PATTERN_SEL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LEAD: begin
                if (cnt_r == LEAD_LAST) begin
                    state_s = ST_ACTIVE;
                    cnt_s   = '0;
                    col_s   = '0;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (col_r == COL_LAST) begin
                    state_s = ST_HBLK;
                    col_s   = '0;
                    cnt_s   = '0;
                end else begin
                    col_s = col_r + 1'b1;
                end
            end
            ST_HBLK: begin
                if (cnt_r == HB_LAST) begin
                    cnt_s = '0;
                    if (line_r == LINE_LAST) begin
                        state_s = ST_VBLK;
                        line_s  = '0;
                    end else begin
                        state_s = ST_ACTIVE;
                        line_s  = line_r + 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_VBLK: begin
                if (cnt_r == VB_LAST) begin
                    cnt_s = '0;
                    if (ENABLE) begin
                        state_s = ST_LEAD;
                        sel_s   = PATTERN_SEL;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                col_s   = '0;
                line_s  = '0;
                cnt_s   = '0;
            end
        endcase
    end

    // State and position registers
    always_ff @(posedge PIXCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
            col_r   <= '0;
            line_r  <= '0;
            cnt_r   <= '0;
            sel_r   <= PATTERN_RAMP;
        end else begin
            state_r <= state_s;
            col_r   <= col_s;
            line_r  <= line_s;
            cnt_r   <= cnt_s;
            sel_r   <= sel_s;
        end
    end

    assign fv_s = (state_r == ST_LEAD) || (state_r == ST_ACTIVE) || (state_r == ST_HBLK);
    assign lv_s = (state_r == ST_ACTIVE);

`ifdef CAMERA_EMULATOR_NOISE_EN
    logic [15:0] lfsr_r;

    // Dither source steps once per emitted pixel
    always_ff @(posedge PIXCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lfsr_r <= LFSR_SEED;
        end else if (state_r == ST_ACTIVE) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign data_s = lv_s ? (pixel_s ^ {8'h00, lfsr_r[1:0]}) : 10'h000;
`else
    assign data_s = lv_s ? pixel_s : 10'h000;
`endif

    // Bus outputs lag the state by one cycle; the frame counter steps as FRAME_VALID falls
    always_ff @(posedge PIXCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            FRAME_VALID <= 1'b0;
            LINE_VALID  <= 1'b0;
            DATA_OUT    <= 10'h000;
            FRAME_COUNT <= 8'h00;
        end else begin
            FRAME_VALID <= fv_s;
            LINE_VALID  <= lv_s;
            DATA_OUT    <= data_s;
            FRAME_COUNT <= (FRAME_VALID && !fv_s) ? FRAME_COUNT + 8'h01 : FRAME_COUNT;
        end
    end

endmodule

// File: tb/tb_camera_emulator.sv
// Self-checking bench for camera_emulator with a frame-level reference model and directed scenarios.
module tb_camera_emulator;

    localparam int COLUMNS = 2;
    localparam int LINES   = 3;
    localparam int H_BLANK = 1;
    localparam int V_BLANK = 2;
    localparam int FV_LEAD = 1;
`ifdef CAMERA_EMULATOR_NOISE_EN
    localparam logic [9:0] DMASK = 10'h3FC;
`else
    localparam logic [9:0] DMASK = 10'h3FF;
`endif

    logic       PIXCLK;
    logic       RESET_N;
    logic       ENABLE;
    logic [1:0] PATTERN_SEL;
    logic       FRAME_VALID;
    logic       LINE_VALID;
    logic [9:0] DATA_OUT;
    logic [7:0] FRAME_COUNT;

    camera_emulator #(
        .COLUMNS (COLUMNS),
        .LINES   (LINES),
        .H_BLANK (H_BLANK),
        .V_BLANK (V_BLANK),
        .FV_LEAD (FV_LEAD)
    ) dut (
        .PIXCLK      (PIXCLK),
        .RESET_N     (RESET_N),
        .ENABLE      (ENABLE),
        .PATTERN_SEL (PATTERN_SEL),
        .FRAME_VALID (FRAME_VALID),
        .LINE_VALID  (LINE_VALID),
        .DATA_OUT    (DATA_OUT),
        .FRAME_COUNT (FRAME_COUNT)
    );

    initial begin
        PIXCLK = 1'b0;
        forever #5 PIXCLK = ~PIXCLK;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: whole-frame output sequences ----------------
    typedef struct packed {
        logic       fv;
        logic       lv;
        logic [9:0] d;
    } beat_t;

    beat_t q[$];
    beat_t exp_b;
    int    exp_cnt;

    function automatic logic [9:0] pix(input int sel, input int l, input int c);
        int v;
        case (sel)
            0: v = (l * COLUMNS + c) % 1024;
            1: v = (((l + 1) * 10 + c + 1) % 256) * 4;
            2: v = ((l % 2) != (c % 2)) ? 1023 : 0;
            default: v = 512;
        endcase
        return 10'(v);
    endfunction

    task automatic push_frame(input int sel);
        for (int i = 0; i < FV_LEAD; i++) q.push_back('{1'b1, 1'b0, 10'h000});
        for (int l = 0; l < LINES; l++) begin
            for (int c = 0; c < COLUMNS; c++) q.push_back('{1'b1, 1'b1, pix(sel, l, c)});
            for (int h = 0; h < H_BLANK; h++) q.push_back('{1'b1, 1'b0, 10'h000});
        end
        for (int v = 0; v < V_BLANK; v++) q.push_back('{1'b0, 1'b0, 10'h000});
    endtask

    initial begin
        beat_t nb;
        exp_b   = '0;
        exp_cnt = 0;
        forever begin
            @(posedge PIXCLK or negedge RESET_N);
            if (!RESET_N) begin
                q.delete();
                exp_b   = '0;
                exp_cnt = 0;
            end else begin
                nb = (q.size() > 0) ? q.pop_front() : beat_t'(12'h000);
                if (exp_b.fv && !nb.fv) exp_cnt = (exp_cnt + 1) % 256;
                exp_b = nb;
                if (q.size() == 0 && ENABLE) push_frame(int'(PATTERN_SEL));
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge PIXCLK);
            if (RESET_N) begin
                chk("cyc_fv", {31'd0, FRAME_VALID}, {31'd0, exp_b.fv});
                chk("cyc_lv", {31'd0, LINE_VALID}, {31'd0, exp_b.lv});
                chk("cyc_data", {22'd0, DATA_OUT & DMASK}, {22'd0, exp_b.d & DMASK});
                chk("cyc_count", {24'd0, FRAME_COUNT}, exp_cnt);
            end
        end
    end

    // Captured active pixels for the directed literal checks
    logic [9:0] cap[$];
    initial begin
        forever begin
            @(negedge PIXCLK);
            if (RESET_N && LINE_VALID) cap.push_back(DATA_OUT);
        end
    end

    task automatic wait_fv(input logic lvl, input string nm);
        int n = 0;
        while (FRAME_VALID !== lvl && n < 200) begin
            @(negedge PIXCLK);
            n++;
        end
        chk(nm, {31'd0, FRAME_VALID}, {31'd0, lvl});
    endtask

    task automatic wait_cnt(input int target, input int budget, input string nm);
        int n = 0;
        while (int'(FRAME_COUNT) != target && n < budget) begin
            @(negedge PIXCLK);
            n++;
        end
        chk(nm, {24'd0, FRAME_COUNT}, target);
    endtask

    task automatic check_cap(input string nm, input logic [9:0] exp[]);
        chk({nm, "_len"}, cap.size(), exp.size());
        for (int i = 0; i < exp.size() && i < cap.size(); i++)
            chk(nm, {22'd0, cap[i] & DMASK}, {22'd0, exp[i] & DMASK});
    endtask

    initial begin
        logic [9:0] e5[];
        int t1_tags[6];
        int n;
        t1_tags = '{11, 12, 21, 22, 31, 32};

        RESET_N     = 1'b0;
        ENABLE      = 1'b0;
        PATTERN_SEL = 2'd1;
        #1;
        chk("rst_fv", {31'd0, FRAME_VALID}, 32'd0);
        chk("rst_lv", {31'd0, LINE_VALID}, 32'd0);
        chk("rst_data", {22'd0, DATA_OUT}, 32'd0);
        chk("rst_count", {24'd0, FRAME_COUNT}, 32'd0);
        repeat (3) @(negedge PIXCLK);
        #2 RESET_N = 1'b1;

        // Test 1: coordinate tags, one frame
        @(negedge PIXCLK);
        cap.delete();
        PATTERN_SEL = 2'd1;
        ENABLE      = 1'b1;
        wait_fv(1'b1, "t1_fv_rise");
        chk("t1_lead_lv_low", {31'd0, LINE_VALID}, 32'd0);
        @(negedge PIXCLK);
        chk("t1_lv_after_lead", {31'd0, LINE_VALID}, 32'd1);
        ENABLE = 1'b0;
        wait_cnt(1, 100, "t1_count");
        repeat (3) @(negedge PIXCLK);
        chk("t1_len", cap.size(), 6);
        for (int i = 0; i < 6 && i < cap.size(); i++)
            chk("t1_tag", {24'd0, cap[i][9:2]}, t1_tags[i]);

        // Test 3: ENABLE dropped during line 1, frame still completes
        cap.delete();
        ENABLE = 1'b1;
        n = 0;
        while (cap.size() < 3 && n < 100) begin
            @(negedge PIXCLK);
            #1;
            n++;
        end
        chk("t3_reach_line1", cap.size(), 3);
        ENABLE = 1'b0;
        wait_cnt(2, 100, "t3_count");
        repeat (12) @(negedge PIXCLK);
        chk("t3_len", cap.size(), 6);
        chk("t3_idle_fv", {31'd0, FRAME_VALID}, 32'd0);
        chk("t3_count_hold", {24'd0, FRAME_COUNT}, 32'd2);

        // Test 5: select changed mid-frame only takes effect next frame
        cap.delete();
        PATTERN_SEL = 2'd0;
        ENABLE      = 1'b1;
        wait_fv(1'b1, "t5_fv_rise");
        PATTERN_SEL = 2'd2;
        wait_cnt(3, 100, "t5_count_a");
        wait_fv(1'b1, "t5_fv_rise2");
        ENABLE = 1'b0;
        wait_cnt(4, 100, "t5_count_b");
        repeat (3) @(negedge PIXCLK);
        e5 = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005,
               10'h000, 10'h3FF, 10'h3FF, 10'h000, 10'h000, 10'h3FF};
        check_cap("t5_pix", e5);

        // Test 4: asynchronous reset in the middle of an active line
        PATTERN_SEL = 2'd3;
        ENABLE      = 1'b1;
        n = 0;
        while (LINE_VALID !== 1'b1 && n < 100) begin
            @(negedge PIXCLK);
            n++;
        end
        chk("t4_lv_seen", {31'd0, LINE_VALID}, 32'd1);
        chk("t4_flat", {22'd0, DATA_OUT & DMASK}, {22'd0, 10'h200 & DMASK});
        #2 RESET_N = 1'b0;
        #1;
        chk("t4_fv_drop", {31'd0, FRAME_VALID}, 32'd0);
        chk("t4_lv_drop", {31'd0, LINE_VALID}, 32'd0);
        chk("t4_data_drop", {22'd0, DATA_OUT}, 32'd0);
        chk("t4_count_drop", {24'd0, FRAME_COUNT}, 32'd0);
        @(negedge PIXCLK);
        #2 RESET_N = 1'b1;
        @(negedge PIXCLK);
        wait_fv(1'b1, "t4_restart_fv");
        chk("t4_restart_lead", {31'd0, LINE_VALID}, 32'd0);
        ENABLE = 1'b0;
        wait_cnt(1, 100, "t4_count");

        // Test 6: frame counter wraps 255 -> 0
        PATTERN_SEL = 2'd1;
        ENABLE      = 1'b1;
        wait_cnt(255, 256 * 14, "t6_count_255");
        wait_cnt(0, 40, "t6_count_wrap");
        ENABLE = 1'b0;
        repeat (30) @(negedge PIXCLK);
        chk("t6_idle_fv", {31'd0, FRAME_VALID}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
